// File: rtl/matrix_mult_feeder.sv
// Sequencer for the 4x4 16-bit matrix multiplier: collects A then B from a serial
// element stream, issues load-A / load-B / read commands and returns the product.
module matrix_mult_feeder #(
  parameter int ELEM_W   = 16,
  parameter int MULT_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ELEM_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [16*ELEM_W-1:0] toMultBus,
  output logic                 enable,
  output logic                 RW,
  output logic                 matDecide,
  input  logic [16*ELEM_W-1:0] fromMultBus,
  output logic                 res_valid,
  output logic [16*ELEM_W-1:0] res_data,
  input  logic                 res_ready
);

  localparam int BusW = 16 * ELEM_W;

  typedef enum logic [2:0] {
    LOAD_A, ISSUE_A, LOAD_B, ISSUE_B, WAIT, ISSUE_RD, CAPTURE, OUT
  } stateT;

  stateT             state;
  logic [3:0]        elemCnt;
  logic [2:0]        waitCnt;
  logic [BusW-1:0]   aBuf;
  logic [BusW-1:0]   bBuf;
  logic              accept;
  logic              lastBeat;

  assign accept   = in_valid && in_ready;
  assign lastBeat = (elemCnt == 4'd15);

  // Command outputs default to idle every cycle so each command is a one-cycle pulse;
  // the final beat is merged straight into toMultBus because its buffer slot lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      elemCnt   <= '0;
      waitCnt   <= '0;
      in_ready  <= 1'b0;
      enable    <= 1'b0;
      RW        <= 1'b0;
      matDecide <= 1'b0;
      toMultBus <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      enable    <= 1'b0;
      RW        <= 1'b0;
      matDecide <= 1'b0;
      toMultBus <= '0;
      case (state)
        LOAD_A: begin
          in_ready <= 1'b1;
          if (accept) begin
            aBuf[{elemCnt, 4'b0000} +: ELEM_W] <= in_data;
            elemCnt <= elemCnt + 4'd1;
            if (lastBeat) begin
              in_ready  <= 1'b0;
              state     <= ISSUE_A;
              enable    <= 1'b1;
              RW        <= 1'b1;
              toMultBus <= {in_data, aBuf[BusW-ELEM_W-1:0]};
            end
          end
        end
        ISSUE_A: begin
          in_ready <= 1'b1;
          state    <= LOAD_B;
        end
        LOAD_B: begin
          in_ready <= 1'b1;
          if (accept) begin
            bBuf[{elemCnt, 4'b0000} +: ELEM_W] <= in_data;
            elemCnt <= elemCnt + 4'd1;
            if (lastBeat) begin
              in_ready  <= 1'b0;
              state     <= ISSUE_B;
              enable    <= 1'b1;
              RW        <= 1'b1;
              matDecide <= 1'b1;
              toMultBus <= {in_data, bBuf[BusW-ELEM_W-1:0]};
            end
          end
        end
        ISSUE_B: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == 3'(MULT_LAT - 1)) begin
            state  <= ISSUE_RD;
            enable <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 3'd1;
          end
        end
        ISSUE_RD: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= fromMultBus;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_feeder.sv
// Randomized scoreboard bench for matrix_mult_feeder with a behavioural multiplier
// stand-in; a negedge monitor checks commands, latency and the result handshake.
module tb_matrix_mult_feeder;

  localparam int MultLat = 1;

  typedef logic [15:0] matT [16];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic [255:0] toMultBus;
  logic         enable;
  logic         RW;
  logic         matDecide;
  logic [255:0] fromMultBus;
  logic         res_valid;
  logic [255:0] res_data;
  logic         res_ready;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int results = 0;
  int expectedResults = 0;
  logic holdLow = 1'b0;
  logic forceReady = 1'b0;
  logic [255:0] lastRes = '0;

  logic [255:0] expA[$];
  logic [255:0] expB[$];
  logic [255:0] expProd[$];

  matrix_mult_feeder #(.ELEM_W(16), .MULT_LAT(MultLat)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .toMultBus(toMultBus), .enable(enable), .RW(RW), .matDecide(matDecide),
    .fromMultBus(fromMultBus), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] packMat(input matT m);
    logic [255:0] w = '0;
    for (int n = 0; n < 16; n++) w[16*n +: 16] = m[n];
    return w;
  endfunction

  function automatic matT unpackMat(input logic [255:0] w);
    matT m;
    for (int n = 0; n < 16; n++) m[n] = w[16*n +: 16];
    return m;
  endfunction

  function automatic matT matMul(input matT a, input matT b);
    matT r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [31:0] acc = '0;
        for (int k = 0; k < 4; k++) acc = acc + 32'(a[i*4+k]) * 32'(b[k*4+j]);
        r[i*4+j] = acc[15:0];
      end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stand-in: the bus carries junk except on the cycle after a read command.
  matT  mA;
  logic aLoaded;
  logic [255:0] prod;
  always @(posedge clk) begin
    if (rst) begin
      aLoaded     <= 1'b0;
      fromMultBus <= '0;
    end else begin
      fromMultBus <= {8{$urandom}};
      if (enable && RW && !matDecide) begin
        mA      <= unpackMat(toMultBus);
        aLoaded <= 1'b1;
      end else if (enable && RW && matDecide) begin
        prod    <= aLoaded ? packMat(matMul(mA, unpackMat(toMultBus))) : {8{$urandom}};
        aLoaded <= 1'b0;
      end else if (enable && !RW) begin
        fromMultBus <= prod;
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = holdLow ? 1'b0 : (forceReady || ($urandom_range(0, 1) == 1));
    end
  end

  // Monitor: command sequence, latency, result scoreboard and output handshake.
  int   beats = 0;
  int   lastBEdge = 0;
  int   loadBCyc = 0;
  int   cmdIdx = 0;
  logic prevEnable = 1'b0;
  logic heldValid = 1'b0;
  logic handshakePrev = 1'b0;
  logic [255:0] heldData = '0;
  always @(negedge clk) begin
    if (rst) begin
      beats = 0; cmdIdx = 0; prevEnable = 1'b0; heldValid = 1'b0; handshakePrev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        beats++;
        if (beats == 32) begin
          lastBEdge = cyc + 1;
          beats = 0;
        end
      end
      if (enable) begin
        checkBit("enableSingle", prevEnable, 1'b0);
        if (cmdIdx == 0) begin
          checkOutput("cmdA", 256'({RW, matDecide}), 256'(2'b10));
          if (expA.size() == 0) checkBit("expAPresent", 1'b0, 1'b1);
          else checkOutput("packA", toMultBus, expA.pop_front());
          cmdIdx = 1;
        end else if (cmdIdx == 1) begin
          checkOutput("cmdB", 256'({RW, matDecide}), 256'(2'b11));
          if (expB.size() == 0) checkBit("expBPresent", 1'b0, 1'b1);
          else checkOutput("packB", toMultBus, expB.pop_front());
          loadBCyc = cyc;
          cmdIdx = 2;
        end else begin
          checkBit("cmdRdRW", RW, 1'b0);
          checkInt("readGap", cyc - loadBCyc, MultLat + 1);
          cmdIdx = 0;
        end
      end else begin
        checkOutput("idleCmd", 256'({RW, matDecide}), 256'(2'b00));
      end
      prevEnable = enable;

      if (handshakePrev) begin
        checkBit("validDrop", res_valid, 1'b0);
        checkBit("readyRise", in_ready, 1'b1);
      end
      if (res_valid) begin
        checkBit("inReadyLowInOut", in_ready, 1'b0);
        if (!heldValid) begin
          checkInt("latency", cyc - lastBEdge, 3 + MultLat);
          if (expProd.size() == 0) checkBit("expProdPresent", 1'b0, 1'b1);
          else checkOutput("product", res_data, expProd.pop_front());
          lastRes = res_data;
        end else begin
          checkOutput("resStable", res_data, heldData);
        end
      end else if (heldValid) begin
        checkBit("validHeld", res_valid, 1'b1);
      end
      handshakePrev = res_valid && res_ready;
      heldValid = res_valid && !res_ready;
      heldData = res_data;
      if (res_valid && res_ready) results++;
    end
  end

  task automatic applyStimulus(input matT a, input matT b, input int gapPct, input int stopAfter);
    logic accepted;
    expA.push_back(packMat(a));
    expB.push_back(packMat(b));
    expProd.push_back(packMat(matMul(a, b)));
    if (stopAfter == 32) expectedResults++;
    for (int n = 0; n < stopAfter; n++) begin
      while ($urandom_range(0, 99) < gapPct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = (n < 16) ? a[n] : b[n-16];
      accepted = 1'b0;
      for (int t = 0; t < 300 && !accepted; t++) begin
        @(negedge clk);
        if (in_ready) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!accepted) checkBit("beatTimeout", 1'b0, 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic waitResults();
    for (int t = 0; t < 1000 && results < expectedResults; t++) @(posedge clk);
    #1;
    checkInt("resultCount", results, expectedResults);
  endtask

  function automatic matT fillMat(input logic [15:0] v);
    matT m;
    for (int n = 0; n < 16; n++) m[n] = v;
    return m;
  endfunction

  function automatic matT randMat();
    matT m;
    for (int n = 0; n < 16; n++) m[n] = 16'($urandom);
    return m;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    matT a, b;
    logic seenValid;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkBit("rstInReady", in_ready, 1'b0);
    checkBit("rstEnable", enable, 1'b0);
    checkBit("rstRW", RW, 1'b0);
    checkBit("rstMatDecide", matDecide, 1'b0);
    checkOutput("rstToMult", toMultBus, '0);
    checkBit("rstResValid", res_valid, 1'b0);
    checkOutput("rstResData", res_data, '0);
    rst = 1'b0;

    $display("[TB] identity x 1..16");
    for (int n = 0; n < 16; n++) begin
      a[n] = (n % 5 == 0) ? 16'h0001 : 16'h0000;
      b[n] = 16'(n + 1);
    end
    applyStimulus(a, b, 0, 32);
    waitResults();
    checkOutput("elem5", 256'(lastRes[80 +: 16]), 256'(16'h0006));

    $display("[TB] constant and overflow patterns");
    applyStimulus(fillMat(16'h0002), fillMat(16'h0003), 0, 32);
    waitResults();
    checkOutput("allEighteen", lastRes, packMat(fillMat(16'h0018)));
    applyStimulus(fillMat(16'h0100), fillMat(16'h0100), 0, 32);
    waitResults();
    checkOutput("overflowZero", lastRes, '0);
    applyStimulus(fillMat(16'h00FF), fillMat(16'h0001), 0, 32);
    waitResults();
    checkOutput("allThreeFC", lastRes, packMat(fillMat(16'h03FC)));

    $display("[TB] backpressure");
    holdLow = 1'b1;
    applyStimulus(randMat(), randMat(), 0, 32);
    seenValid = 1'b0;
    for (int t = 0; t < 200 && !seenValid; t++) begin
      @(negedge clk);
      seenValid = res_valid;
    end
    checkBit("bpValidSeen", seenValid, 1'b1);
    repeat (10) @(posedge clk);
    forceReady = 1'b1;
    holdLow = 1'b0;
    waitResults();
    forceReady = 1'b0;

    $display("[TB] back-to-back with input gaps");
    applyStimulus(randMat(), randMat(), 50, 32);
    applyStimulus(randMat(), randMat(), 50, 32);
    waitResults();

    $display("[TB] reset after seventh B beat");
    applyStimulus(randMat(), randMat(), 30, 23);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expA.delete();
    expB.delete();
    expProd.delete();
    checkBit("midRstEnable", enable, 1'b0);
    checkBit("midRstResValid", res_valid, 1'b0);
    checkBit("midRstInReady", in_ready, 1'b0);
    a = randMat();
    b = randMat();
    applyStimulus(a, b, 20, 32);
    waitResults();
    checkOutput("postRstProduct", lastRes, packMat(matMul(a, b)));

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/matrix_mult_feeder.md
Name: matrix_mult_feeder

Overview:
Upstream sequencer for the 4x4 16-bit matrix multiplier. It accepts a serial stream of 32 elements over a valid/ready handshake: 16 elements for matrix A, then 16 for matrix B. It packs each matrix into a 256-bit word and drives the multiplier's load-A, load-B/compute and read-out command sequence. It then returns the 256-bit product to the consumer over a valid/ready handshake.

Parameters:
ELEM_W, 16, element width; only 16 is supported, fixed by the multiplier bus format
MULT_LAT, 1, idle cycles inserted between the load-B command and the read command (range 1..7)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  element stream valid
in_data  input  16  element; row-major, A first then B
in_ready  output  1  element accepted on a posedge where in_valid && in_ready
toMultBus  output  256  packed matrix to multiplier data input
enable  output  1  multiplier command strobe
RW  output  1  1 = load matrix, 0 = read result
matDecide  output  1  0 = load A (clears accumulator), 1 = load B and compute
fromMultBus  input  256  multiplier result bus
res_valid  output  1  product word valid
res_data  output  256  packed product, same layout as toMultBus
res_ready  input  1  consumer accepts on a posedge where res_valid && res_ready

Behaviour:
- Packing: element n (0..15) of a matrix, row i = n/4, col j = n%4, goes to bits [64*i+16*j +: 16], i.e. [16*n +: 16].
- Reset values: in_ready=0, enable=0, RW=0, matDecide=0, toMultBus=0, res_valid=0, res_data=0. The element counter clears and the FSM goes to LOAD_A.
- The multiplier's fleg pulse lasts only half a cycle and is not consumed. The handshake to the multiplier is fixed-latency: each command is a single cycle with enable=1, sampled by the multiplier on the next posedge.
- LOAD_A: in_ready=1. Each accepted beat writes the slot at the counter, then the counter increments. On the 16th beat the next state is ISSUE_A and the counter wraps to 0.
- ISSUE_A: exactly one cycle with enable=1, RW=1, matDecide=0, toMultBus = packed A. Next state is LOAD_B.
- LOAD_B: same as LOAD_A, into the B buffer. On the 16th beat the next state is ISSUE_B.
- ISSUE_B: one cycle with enable=1, RW=1, matDecide=1, toMultBus = packed B. Next state is WAIT.
- WAIT: MULT_LAT cycles with enable=0. Next state is ISSUE_RD.
- ISSUE_RD: one cycle with enable=1, RW=0. Next state is CAPTURE.
- CAPTURE: one cycle with enable=0. res_data <= fromMultBus, res_valid <= 1. Next state is OUT.
- OUT: res_valid and res_data are held stable until res_ready is sampled high. Then res_valid drops and the next state is LOAD_A.
- Latency: the last B beat is accepted at edge E0; res_valid is first high after edge E0+3+MULT_LAT (E0+4 at default).
- enable is never high for two consecutive cycles. Outside the ISSUE_* states: enable=0, RW=0, matDecide=0.
- A is always issued before B on every transaction, so the multiplier accumulator is cleared before each product.
- in_ready=0 in every state except LOAD_A and LOAD_B. in_valid is ignored while in_ready=0, and in_valid gaps simply stall the counter.
- Arithmetic is performed in the multiplier: products and sums are modulo 2^16. The feeder forwards fromMultBus unmodified.
- rst mid-operation: on the next edge the FSM returns to LOAD_A, the counter clears, any enable drops, and any pending res_valid drops with its result discarded. Partial A/B contents are discarded logically; the buffers need not be cleared.
- Buffer state is not held in the multiplier across rst, so a full A+B stream is required after reset.

Test Plan:
- A = identity (diag 0x0001), B = elements 1..16 -> res_data equals packed B; element 5 is 0x0006 at bits [80+:16].
- A all 0x0002, B all 0x0003 -> every result element is 0x0018; res_valid rises 4 cycles after the last B beat (MULT_LAT=1).
- Overflow: A all 0x0100, B all 0x0100 -> every element is 0x0000 (4*0x10000 mod 2^16). Also A all 0x00FF, B all 0x0001 -> 0x03FC.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stay stable and in_ready stays 0; assert res_ready -> res_valid drops next edge and in_ready rises.
- Random in_valid gaps (50%) over two back-to-back transactions -> correct products. Check enable is a one-cycle pulse with sequence (RW,matDecide) = (1,0), (1,1), (0,x), with MULT_LAT idle cycles before the read.
- Assert rst after the 7th B beat -> next edge: LOAD_A, enable=0, res_valid=0. A fresh 32-element stream yields the correct product, uncontaminated by the prior data.
